// File: rtl/apb_regfile_pkg.sv
// Shared types and constants for the APB register-file slave.
package apb_regfile_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [31:0] REGFILE_ID = 32'hA5B0_0001;

endpackage

// File: rtl/apb_regfile_decode.sv
// Combinational byte-address to register-index decode with error detection.
module apb_regfile_decode
  import apb_regfile_pkg::*;
#(
  parameter int PADDR_WIDTH = 32,
  parameter int NUM_REGS    = 16,
  localparam int IDXW       = $clog2(NUM_REGS)
) (
  input  logic [PADDR_WIDTH-1:0] addr,
  input  logic                   wr,
  output logic [IDXW-1:0]        idx,
  output logic                   err
);

  logic misaligned;
  logic out_of_range;
  logic ro_write;

  assign idx          = addr[2 +: IDXW];
  assign misaligned   = |addr[1:0];
  // Any address bit above the index field set means addr >= NUM_REGS*4.
  assign out_of_range = |(addr >> (IDXW + 2));
  assign ro_write     = wr && (idx == '0);
  assign err          = misaligned || out_of_range || ro_write;

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave with a flop-based register file, configurable wait states and a read-only ID register.
module apb_regfile_slave
  import apb_regfile_pkg::*;
#(
  parameter int PADDR_WIDTH  = 32,
  parameter int PWDATA_WIDTH = 32,
  parameter int PRDATA_WIDTH = 32,
  parameter int NUM_REGS     = 16,
  parameter int WAIT_STATES  = 1
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic [PADDR_WIDTH-1:0]  paddr,
  input  logic                    prwd,
  input  logic [PWDATA_WIDTH-1:0] pwdata,
  input  logic                    psel,
  input  logic                    penable,
  output logic [PRDATA_WIDTH-1:0] prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int IDXW = $clog2(NUM_REGS);

  state_t                  state;
  logic [3:0]              wcnt;
  logic [PADDR_WIDTH-1:0]  cap_addr;
  logic                    cap_wr;
  logic [PWDATA_WIDTH-1:0] cap_data;
  logic [PWDATA_WIDTH-1:0] regs [NUM_REGS];

  logic [IDXW-1:0]         idx;
  logic                    dec_err;
  logic                    done;
  logic [PRDATA_WIDTH-1:0] rd_sel;

  apb_regfile_decode #(
    .PADDR_WIDTH (PADDR_WIDTH),
    .NUM_REGS    (NUM_REGS)
  ) u_decode (
    .addr (cap_addr),
    .wr   (cap_wr),
    .idx  (idx),
    .err  (dec_err)
  );

  assign done    = (state == ACCESS) && psel && penable && (wcnt == 4'(WAIT_STATES));
  assign pready  = done;
  assign pslverr = done && dec_err;
  assign rd_sel  = (idx == '0) ? PRDATA_WIDTH'(REGFILE_ID) : PRDATA_WIDTH'(regs[idx]);
  assign prdata  = (done && !cap_wr && !dec_err) ? rd_sel : '0;

  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      state    <= IDLE;
      wcnt     <= '0;
      cap_addr <= '0;
      cap_wr   <= 1'b0;
      cap_data <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state    <= ACCESS;
            cap_addr <= paddr;
            cap_wr   <= prwd;
            cap_data <= pwdata;
            wcnt     <= '0;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (penable) begin
            if (wcnt == 4'(WAIT_STATES)) begin
              state <= IDLE;
              if (cap_wr && !dec_err) begin
                regs[idx] <= cap_data;
              end
            end else begin
              wcnt <= wcnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 SHALL have parameter PADDR_WIDTH, default 32, address bus width.
REQ-002 SHALL have parameter PWDATA_WIDTH, default 32, write data width.
REQ-003 SHALL have parameter PRDATA_WIDTH, default 32, read data width; must equal PWDATA_WIDTH.
REQ-004 SHALL have parameter NUM_REGS, default 16, register count; power of 2, range 2..256.
REQ-005 SHALL have parameter WAIT_STATES, default 1, ACCESS cycles with pready low before completion; range 0..15.
REQ-006 SHALL have port pclock, input, 1, sole clock; all state changes on the rising edge.
REQ-007 SHALL have port preset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port paddr, input, PADDR_WIDTH, byte address.
REQ-009 SHALL have port prwd, input, 1, 1=write, 0=read.
REQ-010 SHALL have port pwdata, input, PWDATA_WIDTH, write data.
REQ-011 SHALL have port psel, input, 1, slave select.
REQ-012 SHALL have port penable, input, 1, access phase.
REQ-013 SHALL have port prdata, output, PRDATA_WIDTH, read data.
REQ-014 SHALL have port pready, output, 1, transfer completion.
REQ-015 SHALL have port pslverr, output, 1, transfer error.

Function
REQ-016 FSM states: IDLE and ACCESS, plus a wait counter wcnt of 4 bits.
REQ-017 IDLE -> ACCESS when psel=1 and penable=0 are sampled (setup phase); paddr, prwd and pwdata captured; wcnt cleared.
REQ-018 In ACCESS with psel=1 and penable=1: wcnt increments each cycle while wcnt<WAIT_STATES.
REQ-019 pready = (state==ACCESS) and psel and penable and (wcnt==WAIT_STATES), combinational from registered state; WAIT_STATES=0 gives a zero-wait completion in the first access cycle.
REQ-020 ACCESS -> IDLE on the completion edge; a setup phase on the following cycle starts a new transfer, so back-to-back transfers need no idle cycle.
REQ-021 ACCESS -> IDLE if psel=0 is sampled; the transfer is aborted with no register write.
REQ-022 Decode error when captured paddr[1:0]!=0, or paddr >= NUM_REGS*4, or a write targets index 0.
REQ-023 Register index = paddr[2 +: log2(NUM_REGS)].
REQ-024 Register 0 is read-only and returns constant ID 32'hA5B0_0001.
REQ-025 A write commits to the register on the completion edge only when there is no decode error; on error the register file is unchanged.
REQ-026 pslverr = pready and error; 0 whenever pready=0.
REQ-027 prdata = selected register when pready=1 and prwd=0 with no error; otherwise all zeros.
REQ-028 Changes to paddr, prwd or pwdata during ACCESS are ignored; captured values are used.

Reset
REQ-029 On preset low, asynchronously: state=IDLE, wcnt=0, registers 1..NUM_REGS-1 = 0, and captured address/data = 0.
REQ-030 During reset: pready=0, pslverr=0, prdata=0.
REQ-031 Reset asserted mid-transfer aborts the transfer with no write.
REQ-032 After preset deassertion, the first transfer is accepted on the first sampled setup phase.

Structure
REQ-033 Shared package apb_regfile_pkg SHALL hold the state enum (IDLE, ACCESS) and the ID constant.
REQ-034 SHALL contain one sub-module, apb_regfile_decode: combinational address-to-index and error decode.
REQ-035 Register storage SHALL be flops, not a memory macro.

Verification
REQ-036 Reset then read 0x0 with WAIT_STATES=1 -> pready low for 1 ACCESS cycle, then prdata=0xA5B00001, pslverr=0.
REQ-037 Write 0xDEADBEEF to 0x8, then read 0x8 -> read returns 0xDEADBEEF, pslverr=0 on both.
REQ-038 Write to 0x0, to 0x6 (misaligned), and to 0x40 (NUM_REGS=16) -> pslverr=1 with pready, and a subsequent readback of all registers shows them unchanged.
REQ-039 Back-to-back writes to 0x4 and 0xC with no idle, WAIT_STATES=0 -> each completes in its first access cycle and both values are stored.
REQ-040 Drop psel in a wait cycle of a write to 0x4 -> no pready, and 0x4 keeps its old value; assert preset mid-write -> all outputs 0 and 0x4 reads 0.
